// File: rtl/apb_master_bridge.sv
// APB master bridge: turns simple request-port transfers into SETUP/ACCESS APB cycles
// towards two slaves, with a wait-state timeout guarding against a hung slave.
module apb_master_bridge #(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [AW-1:0] apb_read_paddr,
  input  logic [DW-1:0] apb_write_data,
  output logic [DW-1:0] apb_read_data_out,
  output logic          rd_valid,
  output logic          err_out,
  output logic          psel1,
  output logic          psel2,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q;
  logic [CntW-1:0] wait_q;

  logic [AW-1:0] req_addr;
  logic          timeout_hit;
  logic          done;
  logic          capture;

  always_comb begin
    req_addr    = read_write ? apb_read_paddr : apb_write_paddr;
    timeout_hit = !pready && (wait_q == CntW'(TIMEOUT - 1));
    done        = (state_q == StAccess) && (pready || timeout_hit);
    // Requests are only accepted in IDLE or on the edge that completes an ACCESS.
    capture     = transfer && ((state_q == StIdle) || done);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q           <= StIdle;
      wait_q            <= '0;
      apb_read_data_out <= '0;
      rd_valid          <= 1'b0;
      err_out           <= 1'b0;
      psel1             <= 1'b0;
      psel2             <= 1'b0;
      penable           <= 1'b0;
      pwrite            <= 1'b0;
      paddr             <= '0;
      pwdata            <= '0;
    end else begin
      rd_valid <= 1'b0;
      err_out  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (transfer) begin
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          if (done) begin
            wait_q  <= '0;
            penable <= 1'b0;
            if (pready && !pslverr) begin
              if (!pwrite) begin
                apb_read_data_out <= prdata;
                rd_valid          <= 1'b1;
              end
            end else begin
              err_out <= 1'b1;
            end
            if (transfer) begin
              state_q <= StSetup;
            end else begin
              psel1   <= 1'b0;
              psel2   <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Loading here overrides the psel clear above on a back-to-back completion.
      if (capture) begin
        pwrite <= ~read_write;
        paddr  <= req_addr;
        pwdata <= apb_write_data;
        psel1  <= ~req_addr[AW-1];
        psel2  <= req_addr[AW-1];
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; completions are checked against a queue of expected results.
module tb_apb_master_bridge;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       transfer;
  logic       read_write;
  logic [8:0] apb_write_paddr;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] apb_read_data_out;
  logic       rd_valid;
  logic       err_out;
  logic       psel1;
  logic       psel2;
  logic       penable;
  logic       pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } cpl_t;

  cpl_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.AW(9), .DW(8), .TIMEOUT(16)) dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out),
    .rd_valid          (rd_valid),
    .err_out           (err_out),
    .psel1             (psel1),
    .psel2             (psel2),
    .penable           (penable),
    .pwrite            (pwrite),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .prdata            (prdata),
    .pready            (pready),
    .pslverr           (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic cyc();
    @(negedge pclk);
  endtask

  // Completion monitor: every rd_valid/err_out pulse must match the oldest expectation.
  always @(negedge pclk) begin
    if (presetn === 1'b1 && (rd_valid === 1'b1 || err_out === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", {30'd0, rd_valid, err_out}, 32'd0);
      end else begin
        cpl_t e;
        e = exp_q.pop_front();
        chk("cpl_err_out", {31'd0, err_out}, {31'd0, e.is_err});
        chk("cpl_rd_valid", {31'd0, rd_valid}, {31'd0, ~e.is_err});
        if (!e.is_err) chk("cpl_rdata", {24'd0, apb_read_data_out}, {24'd0, e.data});
      end
    end
  end

  initial begin
    int en_cnt;
    int gone;
    presetn = 1'b0; transfer = 1'b0; read_write = 1'b0;
    apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    cyc();
    chk("rst_outputs", {psel1, psel2, penable, pwrite, rd_valid, err_out, paddr, pwdata,
                        apb_read_data_out}, 32'd0);
    presetn = 1'b1;
    cyc();

    // Reset mid-ACCESS of a hanging write
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h0AA; apb_write_data = 8'h77;
    cyc();
    transfer = 1'b0;
    chk("midrst_setup_psel1", {31'd0, psel1}, 32'd1);
    cyc();
    chk("midrst_access_penable", {31'd0, penable}, 32'd1);
    #2 presetn = 1'b0;
    #1 chk("midrst_outputs", {psel1, psel2, penable, pwrite, rd_valid, err_out, paddr, pwdata,
                              apb_read_data_out}, 32'd0);
    cyc();
    cyc();
    presetn = 1'b1;
    cyc();
    chk("midrst_idle", {29'd0, psel1, psel2, penable}, 32'd0);

    // Write to slave 1, zero wait
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h012; apb_write_data = 8'hA5;
    pready = 1'b1;
    cyc();
    transfer = 1'b0;
    chk("wr_setup_ctl", {28'd0, psel1, psel2, penable, pwrite}, 32'b1001);
    chk("wr_setup_addr", {23'd0, paddr}, 32'h012);
    chk("wr_setup_data", {24'd0, pwdata}, 32'hA5);
    cyc();
    chk("wr_access_ctl", {28'd0, psel1, psel2, penable, pwrite}, 32'b1011);
    cyc();
    chk("wr_idle_ctl", {29'd0, psel1, psel2, penable}, 32'd0);
    chk("wr_idle_addr_held", {23'd0, paddr}, 32'h012);

    // Back-to-back write (slave 1) then read (slave 2)
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h005; apb_write_data = 8'h11;
    cyc();
    chk("b2b_w_setup", {28'd0, psel1, psel2, penable, pwrite}, 32'b1001);
    chk("b2b_w_addr", {23'd0, paddr}, 32'h005);
    read_write = 1'b1; apb_read_paddr = 9'h105; prdata = 8'h5A;
    exp_q.push_back('{is_err: 1'b0, data: 8'h5A});
    cyc();
    chk("b2b_w_access", {28'd0, psel1, psel2, penable, pwrite}, 32'b1011);
    cyc();
    transfer = 1'b0;
    chk("b2b_r_setup", {28'd0, psel1, psel2, penable, pwrite}, 32'b0100);
    chk("b2b_r_addr", {23'd0, paddr}, 32'h105);
    cyc();
    chk("b2b_r_access", {28'd0, psel1, psel2, penable, pwrite}, 32'b0110);
    cyc();
    chk("b2b_idle", {29'd0, psel1, psel2, penable}, 32'd0);
    chk("b2b_rdata", {24'd0, apb_read_data_out}, 32'h5A);

    // Read from slave 2 with 3 wait states
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h1F0; pready = 1'b0; prdata = 8'h3C;
    exp_q.push_back('{is_err: 1'b0, data: 8'h3C});
    cyc();
    transfer = 1'b0;
    chk("rd_setup", {28'd0, psel1, psel2, penable, pwrite}, 32'b0100);
    chk("rd_setup_addr", {23'd0, paddr}, 32'h1F0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rd_access_%0d", i), {29'd0, psel1, psel2, penable}, 32'b011);
      chk($sformatf("rd_wait_novalid_%0d", i), {31'd0, rd_valid}, 32'd0);
      if (i == 3) pready = 1'b1;
    end
    cyc();
    chk("rd_idle", {29'd0, psel1, psel2, penable}, 32'd0);
    chk("rd_data", {24'd0, apb_read_data_out}, 32'h3C);
    cyc();
    chk("rd_valid_single", {31'd0, rd_valid}, 32'd0);

    // Slave error on a read
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h033; pready = 1'b1;
    pslverr = 1'b1; prdata = 8'hFF;
    exp_q.push_back('{is_err: 1'b1, data: 8'h00});
    cyc();
    transfer = 1'b0;
    cyc();
    chk("err_access", {29'd0, psel1, psel2, penable}, 32'b101);
    cyc();
    chk("err_data_held", {24'd0, apb_read_data_out}, 32'h3C);
    pslverr = 1'b0;
    cyc();
    chk("err_single_pulse", {30'd0, err_out, rd_valid}, 32'd0);

    // Timeout on a hung write
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h1AB; apb_write_data = 8'hC3;
    pready = 1'b0;
    exp_q.push_back('{is_err: 1'b1, data: 8'h00});
    cyc();
    transfer = 1'b0;
    en_cnt = 0;
    gone = 0;
    for (int i = 0; i < 40 && gone == 0; i++) begin
      cyc();
      if (penable === 1'b1) en_cnt++;
      else if (en_cnt > 0) gone = 1;
    end
    chk("to_released", gone, 32'd1);
    chk("to_penable_cycles", en_cnt, 32'd16);
    chk("to_idle", {29'd0, psel1, psel2, penable}, 32'd0);

    // Normal read after a timeout
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h044; pready = 1'b1; prdata = 8'h96;
    exp_q.push_back('{is_err: 1'b0, data: 8'h96});
    cyc();
    transfer = 1'b0;
    chk("post_to_setup", {28'd0, psel1, psel2, penable, pwrite}, 32'b1000);
    cyc();
    cyc();
    chk("post_to_data", {24'd0, apb_read_data_out}, 32'h96);
    cyc();
    cyc();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
